// File: rtl/ieee754_alu_arbiter.sv
// Round-robin front end for a shared combinational ieee754_alu.
// Two requesters compete for the ALU; the winner's operands are held on the
// ALU inputs for ALU_WAIT cycles, then the result and flags are captured and
// returned on one response channel that carries the requester id.
module ieee754_alu_arbiter #(
  parameter int unsigned ALU_WAIT = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_err,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out_ieee,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  input  logic        alu_gt,
  input  logic        alu_lt,
  input  logic        alu_eq,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [2:0] OP_LAST_LEGAL = 3'b100;
  localparam logic [3:0] WAIT_LOAD     = 4'(ALU_WAIT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_q;
  logic        illegal_q;
  logic [2:0]  alu_opcode_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic [4:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic        busy_q;

  logic        grant_d;
  logic        fire_d;
  logic [2:0]  opcode_d;
  logic [31:0] a_d;
  logic [31:0] b_d;

  // Round-robin grant: a lone valid requester wins, contention goes to the one not served last.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely combinational (no latch).
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_q;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign req0_ready = (state_q == S_IDLE) && !grant_d;
  assign req1_ready = (state_q == S_IDLE) &&  grant_d;

  assign fire_d   = grant_d ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign opcode_d = grant_d ? req1_opcode : req0_opcode;
  assign a_d      = grant_d ? req1_a      : req0_a;
  assign b_d      = grant_d ? req1_b      : req0_b;

  // Sequencing FSM with registered ALU operands and response fields.
  // An illegal opcode skips the ALU entirely: its counter is loaded with 1 so
  // the error response appears with fixed latency independent of ALU_WAIT,
  // and the ALU operand registers are left untouched.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      illegal_q    <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire_d) begin
            last_q   <= grant_d;
            rsp_id_q <= grant_d;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
            if (opcode_d <= OP_LAST_LEGAL) begin
              alu_opcode_q <= opcode_d;
              alu_a_q      <= a_d;
              alu_b_q      <= b_d;
              cnt_q        <= WAIT_LOAD;
              illegal_q    <= 1'b0;
            end else begin
              cnt_q     <= 4'd1;
              illegal_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd1) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            if (illegal_q) begin
              rsp_result_q <= '0;
              rsp_flags_q  <= '0;
              rsp_err_q    <= 1'b1;
            end else begin
              rsp_result_q <= alu_out_ieee;
              rsp_flags_q  <= {alu_overflow, alu_underflow, alu_gt, alu_lt, alu_eq};
              rsp_err_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ieee754_alu_arbiter.sv
// Directed bench for ieee754_alu_arbiter: one instance with ALU_WAIT=1 and one
// with ALU_WAIT=3, each driven by a stub ALU that answers known operand sets.
module tb_ieee754_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;   // {overflow, underflow, gt, lt, eq}
  } alu_res_t;

  // Stub ALU: hand-computed IEEE-754 answers for the operand sets used here.
  function automatic alu_res_t alu_stub(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_res_t r;
    case ({op, a, b})
      {3'b001, 32'hC1200000, 32'hC1A00000}: r = '{32'hC1F00000, 5'b00000}; // -10 + -20
      {3'b011, 32'hC1200000, 32'h41A00000}: r = '{32'hC3480000, 5'b00000}; // -10 * 20
      {3'b100, 32'hC1F00000, 32'hC1200000}: r = '{32'h40400000, 5'b00000}; // -30 / -10
      {3'b010, 32'hC1F00000, 32'hC1200000}: r = '{32'hC1A00000, 5'b00000}; // -30 - -10
      {3'b000, 32'hC1200000, 32'hC1A00000}: r = '{32'h3F800000, 5'b00100}; // -10 > -20
      {3'b000, 32'hC1A00000, 32'hC1A00000}: r = '{32'h00000000, 5'b00001}; // equal
      {3'b011, 32'h7F000000, 32'h7F000000}: r = '{32'h7F800000, 5'b10000}; // overflow
      {3'b100, 32'h00800000, 32'h7F000000}: r = '{32'h00000000, 5'b01000}; // underflow
      default:                              r = '{32'hDEADBEEF, 5'b11111};
    endcase
    return r;
  endfunction

  // ---------------- DUT with ALU_WAIT = 1 ----------------
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_opcode = '0, req1_opcode = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;
  logic [31:0] rsp_result, alu_a, alu_b, alu_out_ieee;
  logic [4:0]  rsp_flags;
  logic [2:0]  alu_opcode;
  logic        alu_overflow, alu_underflow, alu_gt, alu_lt, alu_eq;

  assign {alu_out_ieee, alu_overflow, alu_underflow, alu_gt, alu_lt, alu_eq} = alu_stub(alu_opcode, alu_a, alu_b);

  ieee754_alu_arbiter #(.ALU_WAIT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out_ieee(alu_out_ieee), .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
    .alu_gt(alu_gt), .alu_lt(alu_lt), .alu_eq(alu_eq),
    .busy(busy)
  );

  // ---------------- DUT with ALU_WAIT = 3 ----------------
  logic        w3_rst = 1'b1;
  logic        w3_req0_valid = 1'b0, w3_req1_valid = 1'b0;
  logic        w3_req0_ready, w3_req1_ready;
  logic [2:0]  w3_req0_opcode = '0, w3_req1_opcode = '0;
  logic [31:0] w3_req0_a = '0, w3_req0_b = '0, w3_req1_a = '0, w3_req1_b = '0;
  logic        w3_rsp_valid, w3_rsp_ready = 1'b1, w3_rsp_id, w3_rsp_err, w3_busy;
  logic [31:0] w3_rsp_result, w3_alu_a, w3_alu_b, w3_alu_out_ieee;
  logic [4:0]  w3_rsp_flags;
  logic [2:0]  w3_alu_opcode;
  logic        w3_alu_overflow, w3_alu_underflow, w3_alu_gt, w3_alu_lt, w3_alu_eq;

  assign {w3_alu_out_ieee, w3_alu_overflow, w3_alu_underflow, w3_alu_gt, w3_alu_lt, w3_alu_eq} =
    alu_stub(w3_alu_opcode, w3_alu_a, w3_alu_b);

  ieee754_alu_arbiter #(.ALU_WAIT(3)) u_dut_w3 (
    .clk(clk), .rst(w3_rst),
    .req0_valid(w3_req0_valid), .req0_ready(w3_req0_ready), .req0_opcode(w3_req0_opcode), .req0_a(w3_req0_a), .req0_b(w3_req0_b),
    .req1_valid(w3_req1_valid), .req1_ready(w3_req1_ready), .req1_opcode(w3_req1_opcode), .req1_a(w3_req1_a), .req1_b(w3_req1_b),
    .rsp_valid(w3_rsp_valid), .rsp_ready(w3_rsp_ready), .rsp_id(w3_rsp_id), .rsp_result(w3_rsp_result),
    .rsp_flags(w3_rsp_flags), .rsp_err(w3_rsp_err),
    .alu_opcode(w3_alu_opcode), .alu_a(w3_alu_a), .alu_b(w3_alu_b),
    .alu_out_ieee(w3_alu_out_ieee), .alu_overflow(w3_alu_overflow), .alu_underflow(w3_alu_underflow),
    .alu_gt(w3_alu_gt), .alu_lt(w3_alu_lt), .alu_eq(w3_alu_eq),
    .busy(w3_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request on the ALU_WAIT=1 instance and hold it until accepted.
  // Returns one nanosecond after the accepting edge.
  task automatic send(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    int   i;
    ok = 1'b0;
    i  = 0;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; end
    while (!ok && i < 20) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
      @(posedge clk); #1;
      i++;
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    check("accepted", 32'(ok), 32'd1);
  endtask

  // Count clock edges after acceptance until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    int i;
    lat = -1;
    i   = 0;
    while (lat < 0 && i < 40) begin
      @(negedge clk);
      if (rsp_valid) lat = i;
      i++;
    end
  endtask

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          lat;
    logic [2:0]  exp_op;
    logic [31:0] exp_a, exp_b;

    vecs[0] = '{1'b0, 3'b001, 32'hC1200000, 32'hC1A00000, 32'hC1F00000, 5'b00000, 1'b0};
    vecs[1] = '{1'b1, 3'b011, 32'hC1200000, 32'h41A00000, 32'hC3480000, 5'b00000, 1'b0};
    vecs[2] = '{1'b0, 3'b010, 32'hC1F00000, 32'hC1200000, 32'hC1A00000, 5'b00000, 1'b0};
    vecs[3] = '{1'b1, 3'b000, 32'hC1200000, 32'hC1A00000, 32'h3F800000, 5'b00100, 1'b0};
    vecs[4] = '{1'b0, 3'b101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b00000, 1'b1};
    vecs[5] = '{1'b1, 3'b011, 32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b10000, 1'b0};
    vecs[6] = '{1'b0, 3'b100, 32'h00800000, 32'h7F000000, 32'h00000000, 5'b01000, 1'b0};
    vecs[7] = '{1'b1, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b00000, 1'b1};
    vecs[8] = '{1'b0, 3'b000, 32'hC1A00000, 32'hC1A00000, 32'h00000000, 5'b00001, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0; w3_rst = 1'b0;

    // Reset values.
    @(negedge clk);
    check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst_rsp_id",     32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags",  32'(rsp_flags), 32'd0);
    check("rst_rsp_err",    32'(rsp_err), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_a",      alu_a, 32'd0);
    check("rst_alu_b",      alu_b, 32'd0);

    // Table of single transactions with rsp_ready held high.
    exp_op = '0; exp_a = '0; exp_b = '0;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      if (vecs[i].op <= 3'b100) begin
        exp_op = vecs[i].op; exp_a = vecs[i].a; exp_b = vecs[i].b;
      end
      wait_rsp(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vecs[i].id));
      check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("v%0d_flags", i), 32'(rsp_flags), 32'(vecs[i].flags));
      check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
      check($sformatf("v%0d_alu_opcode", i), 32'(alu_opcode), 32'(exp_op));
      check($sformatf("v%0d_alu_a", i), alu_a, exp_a);
      check($sformatf("v%0d_alu_b", i), alu_b, exp_b);
      @(posedge clk); #1;
      check($sformatf("v%0d_rsp_done", i), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end

    // Contention right after reset: req0 wins first, req1 waits its turn.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_valid = 1'b1; req0_opcode = 3'b011; req0_a = 32'hC1200000; req0_b = 32'h41A00000;
    req1_valid = 1'b1; req1_opcode = 3'b100; req1_a = 32'hC1F00000; req1_b = 32'hC1200000;
    @(negedge clk);
    check("cont_req0_ready", 32'(req0_ready), 32'd1);
    check("cont_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("cont_exec_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("cont_rsp0_valid",  32'(rsp_valid), 32'd1);
    check("cont_rsp0_id",     32'(rsp_id), 32'd0);
    check("cont_rsp0_result", rsp_result, 32'hC3480000);
    check("cont_resp_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("cont_rsp0_done", 32'(rsp_valid), 32'd0);
    check("cont_req1_granted", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(lat);
    check("cont_rsp1_latency", 32'(lat), 32'd1);
    check("cont_rsp1_id",      32'(rsp_id), 32'd1);
    check("cont_rsp1_result",  rsp_result, 32'h40400000);
    @(posedge clk); #1;

    // Compare with backpressure; a waiting req0 drops valid before service.
    rsp_ready = 1'b0;
    send(1'b1, 3'b000, 32'hC1200000, 32'hC1A00000);
    req0_valid = 1'b1; req0_opcode = 3'b001; req0_a = 32'hC1200000; req0_b = 32'hC1A00000;
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k),  32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d_id", k),     32'(rsp_id), 32'd1);
      check($sformatf("bp%0d_result", k), rsp_result, 32'h3F800000);
      check($sformatf("bp%0d_flags", k),  32'(rsp_flags), 32'b00100);
      check($sformatf("bp%0d_err", k),    32'(rsp_err), 32'd0);
      check($sformatf("bp%0d_readys", k), 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    check("bp_hold_until_edge", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_done", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_dropped_req%0d", k), 32'({busy, rsp_valid}), 32'd0);
    end

    // ALU_WAIT=3: eq compare, operands held for three EXEC cycles.
    @(posedge clk); #1;
    w3_req0_valid = 1'b1; w3_req0_opcode = 3'b000; w3_req0_a = 32'hC1A00000; w3_req0_b = 32'hC1A00000;
    @(negedge clk);
    check("w3_req0_ready", 32'(w3_req0_ready), 32'd1);
    @(posedge clk); #1 w3_req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("w3_exec%0d_rsp_valid", k), 32'(w3_rsp_valid), 32'd0);
      check($sformatf("w3_exec%0d_busy", k), 32'(w3_busy), 32'd1);
      check($sformatf("w3_exec%0d_alu_a", k), w3_alu_a, 32'hC1A00000);
      check($sformatf("w3_exec%0d_alu_b", k), w3_alu_b, 32'hC1A00000);
    end
    @(negedge clk);
    check("w3_rsp_valid", 32'(w3_rsp_valid), 32'd1);
    check("w3_rsp_id",    32'(w3_rsp_id), 32'd0);
    check("w3_rsp_flags", 32'(w3_rsp_flags), 32'b00001);
    check("w3_rsp_err",   32'(w3_rsp_err), 32'd0);
    @(posedge clk); #1;
    check("w3_rsp_done", 32'(w3_rsp_valid), 32'd0);

    // ALU_WAIT=3: reset on the second EXEC cycle drops the transaction.
    w3_req1_valid = 1'b1; w3_req1_opcode = 3'b001; w3_req1_a = 32'hC1200000; w3_req1_b = 32'hC1A00000;
    @(negedge clk);
    check("w3r_req1_ready", 32'(w3_req1_ready), 32'd1);
    @(posedge clk); #1 w3_req1_valid = 1'b0;
    @(negedge clk);
    check("w3r_busy", 32'(w3_busy), 32'd1);
    @(posedge clk); #1 w3_rst = 1'b1;
    @(posedge clk); #1 w3_rst = 1'b0;
    check("w3r_rsp_valid",  32'(w3_rsp_valid), 32'd0);
    check("w3r_busy_clr",   32'(w3_busy), 32'd0);
    check("w3r_rsp_id",     32'(w3_rsp_id), 32'd0);
    check("w3r_rsp_result", w3_rsp_result, 32'd0);
    check("w3r_rsp_flags",  32'(w3_rsp_flags), 32'd0);
    check("w3r_rsp_err",    32'(w3_rsp_err), 32'd0);
    check("w3r_alu_opcode", 32'(w3_alu_opcode), 32'd0);
    check("w3r_alu_a",      w3_alu_a, 32'd0);
    check("w3r_alu_b",      w3_alu_b, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("w3r_no_rsp%0d", k), 32'(w3_rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    w3_req0_valid = 1'b1; w3_req0_opcode = 3'b001; w3_req0_a = 32'hC1200000; w3_req0_b = 32'hC1A00000;
    @(negedge clk);
    check("w3r_next_ready", 32'(w3_req0_ready), 32'd1);
    @(posedge clk); #1 w3_req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("w3r_next_early", 32'(w3_rsp_valid), 32'd0);
    @(negedge clk);
    check("w3r_next_valid",  32'(w3_rsp_valid), 32'd1);
    check("w3r_next_id",     32'(w3_rsp_id), 32'd0);
    check("w3r_next_result", w3_rsp_result, 32'hC1F00000);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
